square_colour_ctrl: RTL and testbench

- Input controller for the three-square colour display task.
- Turns three raw pushbutton levels into per-square colour indices that feed the square/indicator pixel colouring logic.
- Synchronises and edge-detects the buttons, arbitrates simultaneous presses round-robin, and enforces one shared post-press lockout.
- Flags the all-red and all-orange match conditions.

---
 rtl/square_colour_ctrl_pkg.sv | 40 ++++
 rtl/square_colour_ctrl_if.sv | 28 ++
 rtl/square_colour_ctrl_btn_sync_edge.sv | 35 +++
 rtl/square_colour_ctrl.sv | 145 ++++++++++++++
 tb/tb_square_colour_ctrl.sv | 263 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/square_colour_ctrl_pkg.sv
// square_colour_ctrl_pkg
// Shared types and constants for the three-square colour display task.
// Contents:
//   state_t            - controller FSM states (IDLE, LOCKOUT, RELEASE)
//   WHITE..BLACK       - colour indices, shared with the pixel colouring logic
//   DEFAULT_LOCKOUT_MS - default post-press lockout length in 1 ms ticks
//   next_colour        - colour increment with wrap
//   rr_next, onehot3   - helpers for the three-way round-robin arbiter
package square_colour_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOCKOUT = 2'd1,
    RELEASE = 2'd2
  } state_t;

  localparam logic [2:0] WHITE  = 3'd0;
  localparam logic [2:0] RED    = 3'd1;
  localparam logic [2:0] GREEN  = 3'd2;
  localparam logic [2:0] BLUE   = 3'd3;
  localparam logic [2:0] ORANGE = 3'd4;
  localparam logic [2:0] BLACK  = 3'd5;

  localparam int DEFAULT_LOCKOUT_MS = 200;

  // Wraps from num-1 back to 0; num must be at most 8 to fit the 3-bit index.
  function automatic logic [2:0] next_colour(input logic [2:0] c, input int num);
    return (c == 3'(num - 1)) ? 3'd0 : c + 3'd1;
  endfunction

  // Next button index modulo 3.
  function automatic logic [1:0] rr_next(input logic [1:0] i);
    return (i == 2'd2) ? 2'd0 : i + 2'd1;
  endfunction

  function automatic logic [2:0] onehot3(input logic [1:0] i);
    return 3'b001 << i;
  endfunction

endpackage

// File: rtl/square_colour_ctrl_if.sv
// square_colour_ctrl_if
// Bundles the controller's inputs (tick, enable, raw buttons) and its outputs
// (colour indices, grant, busy, match flags).
// Modports:
//   master - the side that drives tick_1ms/en/btn and observes the results
//   slave  - the controller itself
interface square_colour_ctrl_if;
  logic       tick_1ms;
  logic       en;
  logic [2:0] btn;
  logic [2:0] colour0;
  logic [2:0] colour1;
  logic [2:0] colour2;
  logic [1:0] grant_idx;
  logic       busy;
  logic       match_red;
  logic       match_orange;

  modport master (
    output tick_1ms, en, btn,
    input  colour0, colour1, colour2, grant_idx, busy, match_red, match_orange
  );

  modport slave (
    input  tick_1ms, en, btn,
    output colour0, colour1, colour2, grant_idx, busy, match_red, match_orange
  );
endinterface

// File: rtl/square_colour_ctrl_btn_sync_edge.sv
// btn_sync_edge
// Two-flop synchroniser for one raw pushbutton plus a one-CLK rising-edge pulse.
// Ports:
//   CLK, RST - clock, asynchronous active-high reset
//   din      - raw asynchronous button level
//   level    - synchronised level (second flop)
//   rise     - high for one CLK when the synchronised level goes 0 -> 1
module btn_sync_edge (
  input  logic CLK,
  input  logic RST,
  input  logic din,
  output logic level,
  output logic rise
);

  logic s1, s2, s2_d;

  // s2_d keeps running regardless of the controller's enable, so a button
  // already held when the task is enabled never produces an edge.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      s1   <= 1'b0;
      s2   <= 1'b0;
      s2_d <= 1'b0;
    end else begin
      s1   <= din;
      s2   <= s1;
      s2_d <= s2;
    end
  end

  assign level = s2;
  assign rise  = s2 & ~s2_d;

endmodule

// File: rtl/square_colour_ctrl.sv
// square_colour_ctrl
// Input controller for the three-square colour display task. Synchronises and
// edge-detects three buttons, records presses in a sticky pending register,
// serves them one at a time round-robin, and holds off further service for a
// shared lockout (LOCKOUT_MS ticks) followed by release of the granted button.
// Ports:
//   CLK, RST - clock, asynchronous active-high reset
//   bus      - slave side of square_colour_ctrl_if:
//              tick_1ms, en, btn[2:0] in;
//              colour0..2, grant_idx, busy, match_red, match_orange out
// Parameters: LOCKOUT_MS must be >= 1; NUM_COLOURS must be <= 8.
module square_colour_ctrl
  import square_colour_ctrl_pkg::*;
#(
  parameter int LOCKOUT_MS  = DEFAULT_LOCKOUT_MS,
  parameter int NUM_COLOURS = 6
) (
  input logic                 CLK,
  input logic                 RST,
  square_colour_ctrl_if.slave bus
);

  localparam int TW = $clog2(LOCKOUT_MS + 1);
  localparam logic [TW-1:0] TIMER_LOAD = TW'(LOCKOUT_MS);
  localparam logic [TW-1:0] TIMER_ONE  = TW'(1);

  logic [2:0]    level;
  logic [2:0]    rise;

  state_t        state, state_n;
  logic [TW-1:0] timer, timer_n;
  logic [2:0]    pending, pending_n;
  logic [2:0]    colour_q [3];
  logic [2:0]    colour_n [3];
  logic [1:0]    grant_q, grant_n;
  logic          match_red_q, match_orange_q;

  logic          grant_hit;
  logic [1:0]    grant_sel;
  logic [1:0]    cand;
  logic          held;

  for (genvar i = 0; i < 3; i++) begin : g_sync
    btn_sync_edge u_sync (
      .CLK   (CLK),
      .RST   (RST),
      .din   (bus.btn[i]),
      .level (level[i]),
      .rise  (rise[i])
    );
  end

  // Round-robin search starts just after the last granted button.
  always_comb begin
    grant_hit = 1'b0;
    grant_sel = grant_q;
    cand      = rr_next(grant_q);
    for (int k = 0; k < 3; k++) begin
      if (!grant_hit && pending[cand]) begin
        grant_hit = 1'b1;
        grant_sel = cand;
      end
      cand = rr_next(cand);
    end
  end

  assign held = |(level & onehot3(grant_q));

  always_comb begin
    state_n   = state;
    timer_n   = timer;
    pending_n = pending;
    colour_n  = colour_q;
    grant_n   = grant_q;

    case (state)
      IDLE: begin
        pending_n = pending | rise;
        if (grant_hit) begin
          pending_n = pending_n & ~onehot3(grant_sel);
          for (int j = 0; j < 3; j++) begin
            if (grant_sel == 2'(j)) colour_n[j] = next_colour(colour_q[j], NUM_COLOURS);
          end
          grant_n = grant_sel;
          timer_n = TIMER_LOAD;
          state_n = LOCKOUT;
        end
      end
      // Edges arriving here are deliberately dropped.
      LOCKOUT: begin
        if (bus.tick_1ms) begin
          if (timer <= TIMER_ONE) begin
            timer_n = '0;
            state_n = RELEASE;
          end else begin
            timer_n = timer - TIMER_ONE;
          end
        end
      end
      RELEASE: begin
        pending_n = pending | rise;
        if (!held) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase

    // Disabling the task clears everything except the arbitration pointer.
    if (!bus.en) begin
      state_n   = IDLE;
      timer_n   = '0;
      pending_n = '0;
      for (int j = 0; j < 3; j++) colour_n[j] = WHITE;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state          <= IDLE;
      timer          <= '0;
      pending        <= '0;
      grant_q        <= 2'd2;
      match_red_q    <= 1'b0;
      match_orange_q <= 1'b0;
      for (int j = 0; j < 3; j++) colour_q[j] <= WHITE;
    end else begin
      state          <= state_n;
      timer          <= timer_n;
      pending        <= pending_n;
      grant_q        <= grant_n;
      colour_q       <= colour_n;
      match_red_q    <= (colour_q[0] == RED) && (colour_q[1] == RED) && (colour_q[2] == RED);
      match_orange_q <= (colour_q[0] == ORANGE) && (colour_q[1] == ORANGE) &&
                        (colour_q[2] == ORANGE);
    end
  end

  assign bus.colour0      = colour_q[0];
  assign bus.colour1      = colour_q[1];
  assign bus.colour2      = colour_q[2];
  assign bus.grant_idx    = grant_q;
  assign bus.busy         = (state != IDLE);
  assign bus.match_red    = match_red_q;
  assign bus.match_orange = match_orange_q;

endmodule

// File: tb/tb_square_colour_ctrl.sv
// tb_square_colour_ctrl
// Directed testbench for square_colour_ctrl with LOCKOUT_MS=200 and a
// tick_1ms pulse every TICK_DIV clocks.
module tb_square_colour_ctrl;
  import square_colour_ctrl_pkg::*;

  localparam int LOCKOUT_MS = 200;
  localparam int TICK_DIV   = 4;
  localparam int WAIT_LIMIT = LOCKOUT_MS * TICK_DIV * 3 + 200;

  logic CLK = 1'b0;
  logic RST;
  int   checks = 0;
  int   errors = 0;

  square_colour_ctrl_if bus ();

  square_colour_ctrl #(
    .LOCKOUT_MS  (LOCKOUT_MS),
    .NUM_COLOURS (6)
  ) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  initial begin
    bus.tick_1ms = 1'b0;
    forever begin
      repeat (TICK_DIV - 1) @(negedge CLK);
      bus.tick_1ms = 1'b1;
      @(negedge CLK);
      bus.tick_1ms = 1'b0;
    end
  end

  task automatic press(input int b);
    @(negedge CLK);
    bus.btn[b] = 1'b1;
    repeat (4) @(negedge CLK);
    bus.btn[b] = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge CLK);
    while (bus.busy && n < WAIT_LIMIT) begin
      @(negedge CLK);
      n++;
    end
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL wait_idle_timeout busy=%0b expected 0", bus.busy);
    end
  endtask

  task automatic serve(input int b);
    press(b);
    wait_idle();
    repeat (2) @(negedge CLK);
  endtask

  task automatic clear_en();
    @(negedge CLK);
    bus.en = 1'b0;
    repeat (2) @(negedge CLK);
    bus.en = 1'b1;
    @(negedge CLK);
  endtask

  task automatic test_reset();
    RST = 1'b1; bus.en = 1'b0; bus.btn = 3'b000;
    repeat (3) @(negedge CLK);
    checks++; if (bus.colour0 !== 3'd0 || bus.colour1 !== 3'd0 || bus.colour2 !== 3'd0) begin
      errors++; $display("[TB] FAIL reset_colours got %0d/%0d/%0d expected 0/0/0", bus.colour0, bus.colour1, bus.colour2); end
    checks++; if (bus.grant_idx !== 2'd2) begin
      errors++; $display("[TB] FAIL reset_grant got %0d expected 2", bus.grant_idx); end
    checks++; if (bus.busy !== 1'b0 || bus.match_red !== 1'b0 || bus.match_orange !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_flags busy/red/orange=%0b%0b%0b expected 000", bus.busy, bus.match_red, bus.match_orange); end
    RST = 1'b0; bus.en = 1'b1;
    @(negedge CLK);
    serve(1);
    serve(1);
    press(1);
    repeat (50) @(negedge CLK);
    checks++; if (bus.colour1 !== 3'd3 || bus.busy !== 1'b1) begin
      errors++; $display("[TB] FAIL pre_reset colour1=%0d busy=%0b expected 3/1", bus.colour1, bus.busy); end
    #2 RST = 1'b1;
    #1;
    checks++; if (bus.colour0 !== 3'd0 || bus.colour1 !== 3'd0 || bus.colour2 !== 3'd0) begin
      errors++; $display("[TB] FAIL async_reset_colours got %0d/%0d/%0d expected 0/0/0", bus.colour0, bus.colour1, bus.colour2); end
    checks++; if (bus.busy !== 1'b0 || bus.grant_idx !== 2'd2 || bus.match_red !== 1'b0 || bus.match_orange !== 1'b0) begin
      errors++; $display("[TB] FAIL async_reset_state busy=%0b grant=%0d red=%0b orange=%0b expected 0/2/0/0",
                         bus.busy, bus.grant_idx, bus.match_red, bus.match_orange); end
    @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
    bus.btn[0] = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
    checks++; if (bus.colour0 !== 3'd0) begin
      errors++; $display("[TB] FAIL latency_k2 colour0=%0d expected 0", bus.colour0); end
    @(posedge CLK);
    #1;
    checks++; if (bus.colour0 !== 3'd1 || bus.busy !== 1'b1 || bus.grant_idx !== 2'd0) begin
      errors++; $display("[TB] FAIL latency_k3 colour0=%0d busy=%0b grant=%0d expected 1/1/0", bus.colour0, bus.busy, bus.grant_idx); end
    @(negedge CLK);
    bus.btn[0] = 1'b0;
    wait_idle();
  endtask

  task automatic test_hold();
    clear_en();
    bus.btn[0] = 1'b1;
    repeat (4) @(posedge CLK);
    #1;
    checks++; if (bus.colour0 !== 3'd1 || bus.busy !== 1'b1) begin
      errors++; $display("[TB] FAIL hold_first colour0=%0d busy=%0b expected 1/1", bus.colour0, bus.busy); end
    repeat (500 * TICK_DIV - 10) @(negedge CLK);
    checks++; if (bus.colour0 !== 3'd1 || bus.busy !== 1'b1) begin
      errors++; $display("[TB] FAIL hold_long colour0=%0d busy=%0b expected 1/1", bus.colour0, bus.busy); end
    bus.btn[0] = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    checks++; if (bus.busy !== 1'b1) begin
      errors++; $display("[TB] FAIL hold_release_r1 busy=%0b expected 1", bus.busy); end
    @(posedge CLK);
    #1;
    checks++; if (bus.busy !== 1'b0) begin
      errors++; $display("[TB] FAIL hold_release_r2 busy=%0b expected 0", bus.busy); end
    repeat (20) @(negedge CLK);
    checks++; if (bus.colour0 !== 3'd1) begin
      errors++; $display("[TB] FAIL hold_once colour0=%0d expected 1", bus.colour0); end
  endtask

  task automatic test_simultaneous();
    serve(2);
    clear_en();
    checks++; if (bus.grant_idx !== 2'd2 || bus.colour2 !== 3'd0) begin
      errors++; $display("[TB] FAIL en_clear grant=%0d colour2=%0d expected 2/0", bus.grant_idx, bus.colour2); end
    bus.btn = 3'b101;
    repeat (4) @(posedge CLK);
    #1;
    checks++; if (bus.colour0 !== 3'd1 || bus.colour2 !== 3'd0 || bus.grant_idx !== 2'd0) begin
      errors++; $display("[TB] FAIL simul_first c0=%0d c2=%0d grant=%0d expected 1/0/0", bus.colour0, bus.colour2, bus.grant_idx); end
    @(negedge CLK);
    bus.btn = 3'b000;
    repeat (100) @(negedge CLK);
    checks++; if (bus.colour2 !== 3'd0) begin
      errors++; $display("[TB] FAIL simul_wait colour2=%0d expected 0", bus.colour2); end
    wait_idle();
    checks++; if (bus.colour2 !== 3'd0) begin
      errors++; $display("[TB] FAIL simul_idle colour2=%0d expected 0", bus.colour2); end
    @(posedge CLK);
    #1;
    checks++; if (bus.colour2 !== 3'd1 || bus.grant_idx !== 2'd2 || bus.busy !== 1'b1) begin
      errors++; $display("[TB] FAIL simul_second c2=%0d grant=%0d busy=%0b expected 1/2/1", bus.colour2, bus.grant_idx, bus.busy); end
    wait_idle();
  endtask

  task automatic test_wrap();
    logic [2:0] exp_seq [6];
    exp_seq = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd0};
    clear_en();
    for (int i = 0; i < 6; i++) begin
      serve(1);
      checks++; if (bus.colour1 !== exp_seq[i]) begin
        errors++; $display("[TB] FAIL wrap_step%0d colour1=%0d expected %0d", i, bus.colour1, exp_seq[i]); end
    end
  endtask

  task automatic test_lockout_discard();
    clear_en();
    press(0);
    repeat (20) @(negedge CLK);
    press(2);
    repeat (20) @(negedge CLK);
    press(2);
    wait_idle();
    repeat (10) @(negedge CLK);
    checks++; if (bus.colour2 !== 3'd0 || bus.colour0 !== 3'd1 || bus.busy !== 1'b0) begin
      errors++; $display("[TB] FAIL lockout_discard c0=%0d c2=%0d busy=%0b expected 1/0/0", bus.colour0, bus.colour2, bus.busy); end
  endtask

  task automatic test_match();
    clear_en();
    serve(0);
    serve(1);
    @(negedge CLK);
    bus.btn[2] = 1'b1;
    repeat (4) @(posedge CLK);
    #1;
    checks++; if (bus.colour2 !== 3'd1 || bus.match_red !== 1'b0) begin
      errors++; $display("[TB] FAIL red_k3 colour2=%0d match_red=%0b expected 1/0", bus.colour2, bus.match_red); end
    @(posedge CLK);
    #1;
    checks++; if (bus.match_red !== 1'b1 || bus.match_orange !== 1'b0) begin
      errors++; $display("[TB] FAIL red_k4 match_red=%0b match_orange=%0b expected 1/0", bus.match_red, bus.match_orange); end
    @(negedge CLK);
    bus.btn[2] = 1'b0;
    wait_idle();
    for (int i = 0; i < 3; i++) serve(0);
    for (int i = 0; i < 3; i++) serve(1);
    for (int i = 0; i < 2; i++) serve(2);
    @(negedge CLK);
    bus.btn[2] = 1'b1;
    repeat (4) @(posedge CLK);
    #1;
    checks++; if (bus.colour2 !== 3'd4 || bus.match_orange !== 1'b0) begin
      errors++; $display("[TB] FAIL orange_k3 colour2=%0d match_orange=%0b expected 4/0", bus.colour2, bus.match_orange); end
    @(posedge CLK);
    #1;
    checks++; if (bus.match_orange !== 1'b1 || bus.match_red !== 1'b0) begin
      errors++; $display("[TB] FAIL orange_k4 match_orange=%0b match_red=%0b expected 1/0", bus.match_orange, bus.match_red); end
    @(negedge CLK);
    bus.btn[2] = 1'b0;
    @(negedge CLK);
    bus.en = 1'b0;
    @(posedge CLK);
    #1;
    checks++; if (bus.colour0 !== 3'd0 || bus.colour1 !== 3'd0 || bus.colour2 !== 3'd0 || bus.busy !== 1'b0) begin
      errors++; $display("[TB] FAIL en_low_colours got %0d/%0d/%0d busy=%0b expected 0/0/0/0", bus.colour0, bus.colour1, bus.colour2, bus.busy); end
    checks++; if (bus.match_orange !== 1'b1) begin
      errors++; $display("[TB] FAIL en_low_flag_lag match_orange=%0b expected 1", bus.match_orange); end
    @(posedge CLK);
    #1;
    checks++; if (bus.match_orange !== 1'b0 || bus.match_red !== 1'b0) begin
      errors++; $display("[TB] FAIL en_low_flags orange=%0b red=%0b expected 0/0", bus.match_orange, bus.match_red); end
  endtask

  task automatic test_en_held();
    @(negedge CLK);
    bus.en = 1'b0;
    bus.btn[0] = 1'b1;
    repeat (6) @(negedge CLK);
    bus.en = 1'b1;
    repeat (12) @(negedge CLK);
    checks++; if (bus.colour0 !== 3'd0 || bus.busy !== 1'b0) begin
      errors++; $display("[TB] FAIL en_rise_held colour0=%0d busy=%0b expected 0/0", bus.colour0, bus.busy); end
    bus.btn[0] = 1'b0;
    repeat (4) @(negedge CLK);
  endtask

  initial begin
    RST = 1'b1;
    bus.en = 1'b0;
    bus.btn = 3'b000;
    test_reset();
    test_hold();
    test_simultaneous();
    test_wrap();
    test_lockout_discard();
    test_match();
    test_en_held();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
